// File: rtl/muxn_seq.sv
// muxn_seq: N-channel, WIDTH-bit registered multiplexer with a manual mode
// and an automatic round-robin mode that dwells DWELL enabled cycles on each
// channel. All outputs are registered with one cycle of latency.
//
// Optional feature macro: MUXN_SEQ_SKIP_EN
//   When defined, a per-channel ch_vld input is added and the auto mode
//   skips channels whose ch_vld bit is low while advancing.
//
// Handshake: there is no valid/ready flow control. z_valid qualifies z for
// the consumer on every cycle; the consumer cannot stall the block, and en
// is the only way to hold the output stream.
//
// Debug: dbg_state exposes the FSM state (0 = MAN, 1 = AUTO), and dbg_ptr
// exposes the auto-mode channel pointer.
module muxn_seq #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int DWELL = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*WIDTH-1:0]     d,
  input  logic [$clog2(N)-1:0]   sel,
  input  logic                   mode,
  input  logic                   en,
`ifdef MUXN_SEQ_SKIP_EN
  input  logic [N-1:0]           ch_vld,
`endif
  output logic [WIDTH-1:0]       z,
  output logic [$clog2(N)-1:0]   cur_sel,
  output logic                   z_valid,
  output logic                   sel_err,
  output logic                   dbg_state,
  output logic [$clog2(N)-1:0]   dbg_ptr
);

  localparam int SW = $clog2(N);
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SW:0]   N_W      = (SW+1)'(N);
  localparam logic [SW-1:0] PTR_LAST = SW'(N-1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL-1);

  typedef enum logic {
    ST_MAN  = 1'b0,
    ST_AUTO = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [SW-1:0]    cur_sel_q, cur_sel_d;
  logic             z_valid_q, z_valid_d;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] ch [N];
  logic             sel_ok;
  logic [SW-1:0]    ptr_eff;
  logic [CW-1:0]    cnt_eff;
  logic [SW-1:0]    ptr_adv;
  logic             any_vld;
  logic             cur_vld;

  // Unpack the flat data bus into one word per channel.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      ch[k] = d[k*WIDTH +: WIDTH];
    end
  end

  assign sel_ok = ({1'b0, sel} < N_W);

  // Effective pointer/counter for this edge: a MAN->AUTO entry reloads them
  // from sel so the entry edge already samples the newly selected channel.
  always_comb begin
    ptr_eff = ptr_q;
    cnt_eff = cnt_q;
    if (state_q == ST_MAN) begin
      ptr_eff = sel_ok ? sel : '0;
      cnt_eff = '0;
    end
  end

`ifdef MUXN_SEQ_SKIP_EN
  int   idx;
  logic found;

  // Next pointer: first channel after ptr_eff (with wrap) whose ch_vld is set.
  always_comb begin
    ptr_adv = ptr_eff;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(ptr_eff) + k;
      if (idx >= N) idx = idx - N;
      if (!found && ch_vld[SW'(idx)]) begin
        ptr_adv = SW'(idx);
        found   = 1'b1;
      end
    end
  end

  assign any_vld = |ch_vld;
  assign cur_vld = ch_vld[ptr_eff];
`else
  // Next pointer: strict round-robin with wrap from N-1 to 0.
  always_comb begin
    ptr_adv = (ptr_eff == PTR_LAST) ? '0 : ptr_eff + 1'b1;
  end

  assign any_vld = 1'b1;
  assign cur_vld = 1'b1;
`endif

  // Next-state and output selection; the incoming mode picks the path.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    z_d       = z_q;
    cur_sel_d = cur_sel_q;
    z_valid_d = z_valid_q;
    sel_err_d = sel_err_q;
    if (en) begin
      if (!mode) begin
        state_d = ST_MAN;
        if (sel_ok) begin
          z_d       = ch[sel];
          cur_sel_d = sel;
          z_valid_d = 1'b1;
          sel_err_d = 1'b0;
        end else begin
          z_d       = '0;
          cur_sel_d = '0;
          z_valid_d = 1'b0;
          sel_err_d = 1'b1;
        end
      end else begin
        state_d   = ST_AUTO;
        sel_err_d = 1'b0;
        ptr_d     = ptr_eff;
        if (any_vld) begin
          z_d       = ch[ptr_eff];
          cur_sel_d = ptr_eff;
          z_valid_d = cur_vld;
        end else begin
          z_valid_d = 1'b0;
        end
        if (cnt_eff == CNT_LAST) begin
          cnt_d = '0;
          ptr_d = ptr_adv;
        end else begin
          cnt_d = cnt_eff + 1'b1;
        end
      end
    end
  end

  // State and output registers; reset wins over enable and mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_MAN;
      ptr_q     <= '0;
      cnt_q     <= '0;
      z_q       <= '0;
      cur_sel_q <= '0;
      z_valid_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      z_q       <= z_d;
      cur_sel_q <= cur_sel_d;
      z_valid_q <= z_valid_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign z         = z_q;
  assign cur_sel   = cur_sel_q;
  assign z_valid   = z_valid_q;
  assign sel_err   = sel_err_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_muxn_seq.sv
// tb_muxn_seq: directed bench for muxn_seq. Instance A is N=4/DWELL=2,
// instance B is N=3 (out-of-range select), instance C (only with
// MUXN_SEQ_SKIP_EN) is N=4/DWELL=1 for channel skipping.
module tb_muxn_seq;

  logic clk;
  logic rst;

  // Instance A: N=4, WIDTH=8, DWELL=2
  logic [31:0] d_a;
  logic [1:0]  sel_a;
  logic        mode_a, en_a;
  logic [7:0]  z_a;
  logic [1:0]  cur_sel_a, ptr_a;
  logic        z_valid_a, sel_err_a, st_a;

  // Instance B: N=3, WIDTH=8, DWELL=2
  logic [23:0] d_b;
  logic [1:0]  sel_b;
  logic        mode_b, en_b;
  logic [7:0]  z_b;
  logic [1:0]  cur_sel_b, ptr_b;
  logic        z_valid_b, sel_err_b, st_b;

  int checks;
  int failures;

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  muxn_seq #(.N(4), .WIDTH(8), .DWELL(2)) u_dut_a (
    .clk(clk), .rst(rst), .d(d_a), .sel(sel_a), .mode(mode_a), .en(en_a),
`ifdef MUXN_SEQ_SKIP_EN
    .ch_vld(4'b1111),
`endif
    .z(z_a), .cur_sel(cur_sel_a), .z_valid(z_valid_a), .sel_err(sel_err_a),
    .dbg_state(st_a), .dbg_ptr(ptr_a)
  );

  muxn_seq #(.N(3), .WIDTH(8), .DWELL(2)) u_dut_b (
    .clk(clk), .rst(rst), .d(d_b), .sel(sel_b), .mode(mode_b), .en(en_b),
`ifdef MUXN_SEQ_SKIP_EN
    .ch_vld(3'b111),
`endif
    .z(z_b), .cur_sel(cur_sel_b), .z_valid(z_valid_b), .sel_err(sel_err_b),
    .dbg_state(st_b), .dbg_ptr(ptr_b)
  );

`ifdef MUXN_SEQ_SKIP_EN
  // Instance C: N=4, WIDTH=8, DWELL=1, channel skipping
  logic [31:0] d_c;
  logic [1:0]  sel_c;
  logic        mode_c, en_c;
  logic [3:0]  ch_vld_c;
  logic [7:0]  z_c;
  logic [1:0]  cur_sel_c, ptr_c;
  logic        z_valid_c, sel_err_c, st_c;

  muxn_seq #(.N(4), .WIDTH(8), .DWELL(1)) u_dut_c (
    .clk(clk), .rst(rst), .d(d_c), .sel(sel_c), .mode(mode_c), .en(en_c),
    .ch_vld(ch_vld_c),
    .z(z_c), .cur_sel(cur_sel_c), .z_valid(z_valid_c), .sel_err(sel_err_c),
    .dbg_state(st_c), .dbg_ptr(ptr_c)
  );
`endif

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode_a = 1'b1; en_a = 1'b1; sel_a = 2'd1;
    tick();
    tick();
    checks++; if (z_a !== 8'h00) begin failures++; $display("FAIL rst_z got=%h exp=%h", z_a, 8'h00); end
    checks++; if (cur_sel_a !== 2'd0) begin failures++; $display("FAIL rst_cur_sel got=%0d exp=%0d", cur_sel_a, 0); end
    checks++; if (z_valid_a !== 1'b0) begin failures++; $display("FAIL rst_z_valid got=%b exp=%b", z_valid_a, 1'b0); end
    checks++; if (sel_err_a !== 1'b0) begin failures++; $display("FAIL rst_sel_err got=%b exp=%b", sel_err_a, 1'b0); end
    checks++; if (st_a !== 1'b0) begin failures++; $display("FAIL rst_state got=%b exp=%b", st_a, 1'b0); end
    checks++; if (ptr_a !== 2'd0) begin failures++; $display("FAIL rst_ptr got=%0d exp=%0d", ptr_a, 0); end
    // First edge after release enters AUTO from MAN and loads ptr from sel=1.
    rst = 1'b0;
    tick();
    checks++; if (st_a !== 1'b1) begin failures++; $display("FAIL rel_state got=%b exp=%b", st_a, 1'b1); end
    checks++; if (cur_sel_a !== 2'd1) begin failures++; $display("FAIL rel_cur_sel got=%0d exp=%0d", cur_sel_a, 1); end
    checks++; if (z_a !== 8'h22) begin failures++; $display("FAIL rel_z got=%h exp=%h", z_a, 8'h22); end
  endtask

  task automatic test_manual();
    logic [1:0] sels [3];
    logic [7:0] exps [3];
    sels = '{2'd2, 2'd0, 2'd3};
    exps = '{8'h33, 8'h11, 8'h44};
    mode_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel_a = sels[i];
      tick();
      checks++; if (z_a !== exps[i]) begin failures++; $display("FAIL man_z[%0d] got=%h exp=%h", i, z_a, exps[i]); end
      checks++; if (cur_sel_a !== sels[i]) begin failures++; $display("FAIL man_cur_sel[%0d] got=%0d exp=%0d", i, cur_sel_a, sels[i]); end
      checks++; if (z_valid_a !== 1'b1 || sel_err_a !== 1'b0) begin failures++; $display("FAIL man_flags[%0d] got=%b%b exp=10", i, z_valid_a, sel_err_a); end
    end
  endtask

  task automatic test_auto();
    logic [7:0] exp_q [$];
    logic [7:0] chv [4];
    logic [7:0] e;
    chv = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q = '{8'd2, 8'd2, 8'd3, 8'd3, 8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3};
    sel_a = 2'd2; mode_a = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      e = exp_q.pop_front();
      checks++; if (cur_sel_a !== e[1:0]) begin failures++; $display("FAIL auto_cur_sel[%0d] got=%0d exp=%0d", i, cur_sel_a, e[1:0]); end
      checks++; if (z_a !== chv[e[1:0]]) begin failures++; $display("FAIL auto_z[%0d] got=%h exp=%h", i, z_a, chv[e[1:0]]); end
      checks++; if (z_valid_a !== 1'b1) begin failures++; $display("FAIL auto_z_valid[%0d] got=%b exp=1", i, z_valid_a); end
    end
    // Reset mid-dwell on channel 3 returns to MAN with ptr 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (st_a !== 1'b0) begin failures++; $display("FAIL mid_rst_state got=%b exp=0", st_a); end
    checks++; if (ptr_a !== 2'd0) begin failures++; $display("FAIL mid_rst_ptr got=%0d exp=0", ptr_a); end
    checks++; if (z_a !== 8'h00 || z_valid_a !== 1'b0) begin failures++; $display("FAIL mid_rst_out got=%h/%b exp=00/0", z_a, z_valid_a); end
  endtask

  task automatic test_enable_freeze();
    mode_a = 1'b1; sel_a = 2'd0; en_a = 1'b1;
    tick();
    checks++; if (cur_sel_a !== 2'd0 || z_a !== 8'h11) begin failures++; $display("FAIL frz_pre got=%0d/%h exp=0/11", cur_sel_a, z_a); end
    en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_a = {8'hA4 + 8'(i), 8'hA3 + 8'(i), 8'hA2 + 8'(i), 8'hA1 + 8'(i)};
      tick();
      checks++; if (z_a !== 8'h11) begin failures++; $display("FAIL frz_z[%0d] got=%h exp=11", i, z_a); end
      checks++; if (cur_sel_a !== 2'd0 || ptr_a !== 2'd0) begin failures++; $display("FAIL frz_sel_ptr[%0d] got=%0d/%0d exp=0/0", i, cur_sel_a, ptr_a); end
    end
    d_a = {8'h44, 8'h33, 8'h22, 8'h11};
    en_a = 1'b1;
    tick();
    checks++; if (cur_sel_a !== 2'd0 || z_a !== 8'h11) begin failures++; $display("FAIL frz_done got=%0d/%h exp=0/11", cur_sel_a, z_a); end
    checks++; if (ptr_a !== 2'd1) begin failures++; $display("FAIL frz_adv_ptr got=%0d exp=1", ptr_a); end
    tick();
    checks++; if (cur_sel_a !== 2'd1 || z_a !== 8'h22) begin failures++; $display("FAIL frz_next got=%0d/%h exp=1/22", cur_sel_a, z_a); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] exp_sel [7];
    logic [7:0] chv [3];
    exp_sel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    chv = '{8'h11, 8'h22, 8'h33};
    en_b = 1'b1; mode_b = 1'b0; sel_b = 2'd3;
    tick();
    checks++; if (z_b !== 8'h00) begin failures++; $display("FAIL oor_z got=%h exp=00", z_b); end
    checks++; if (z_valid_b !== 1'b0 || sel_err_b !== 1'b1) begin failures++; $display("FAIL oor_flags got=%b%b exp=01", z_valid_b, sel_err_b); end
    checks++; if (cur_sel_b !== 2'd0) begin failures++; $display("FAIL oor_cur_sel got=%0d exp=0", cur_sel_b); end
    sel_b = 2'd1;
    tick();
    checks++; if (z_b !== 8'h22) begin failures++; $display("FAIL oor_rec_z got=%h exp=22", z_b); end
    checks++; if (z_valid_b !== 1'b1 || sel_err_b !== 1'b0) begin failures++; $display("FAIL oor_rec_flags got=%b%b exp=10", z_valid_b, sel_err_b); end
    // Entering AUTO with an illegal sel starts from channel 0; N=3 wraps 2->0.
    mode_b = 1'b1; sel_b = 2'd3;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (cur_sel_b !== exp_sel[i] || z_b !== chv[exp_sel[i]]) begin failures++; $display("FAIL oor_auto[%0d] got=%0d/%h exp=%0d/%h", i, cur_sel_b, z_b, exp_sel[i], chv[exp_sel[i]]); end
      checks++; if (sel_err_b !== 1'b0) begin failures++; $display("FAIL oor_auto_err[%0d] got=%b exp=0", i, sel_err_b); end
    end
  endtask

`ifdef MUXN_SEQ_SKIP_EN
  task automatic test_skip();
    logic [1:0] exp_sel [4];
    logic [7:0] chv [4];
    exp_sel = '{2'd1, 2'd3, 2'd1, 2'd3};
    chv = '{8'h11, 8'h22, 8'h33, 8'h44};
    d_c = {8'h44, 8'h33, 8'h22, 8'h11};
    en_c = 1'b1; mode_c = 1'b1; sel_c = 2'd1; ch_vld_c = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (cur_sel_c !== exp_sel[i] || z_c !== chv[exp_sel[i]]) begin failures++; $display("FAIL skip[%0d] got=%0d/%h exp=%0d/%h", i, cur_sel_c, z_c, exp_sel[i], chv[exp_sel[i]]); end
      checks++; if (z_valid_c !== 1'b1) begin failures++; $display("FAIL skip_valid[%0d] got=%b exp=1", i, z_valid_c); end
    end
    ch_vld_c = 4'b0000;
    tick();
    checks++; if (z_valid_c !== 1'b0) begin failures++; $display("FAIL skip_none_valid got=%b exp=0", z_valid_c); end
    checks++; if (z_c !== 8'h44) begin failures++; $display("FAIL skip_none_z got=%h exp=44", z_c); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst    = 1'b1;
    d_a    = {8'h44, 8'h33, 8'h22, 8'h11};
    sel_a  = 2'd0; mode_a = 1'b0; en_a = 1'b0;
    d_b    = {8'h33, 8'h22, 8'h11};
    sel_b  = 2'd0; mode_b = 1'b0; en_b = 1'b0;
`ifdef MUXN_SEQ_SKIP_EN
    d_c    = '0; sel_c = 2'd0; mode_c = 1'b0; en_c = 1'b0; ch_vld_c = 4'b0000;
`endif
    test_reset();
    test_manual();
    test_auto();
    test_enable_freeze();
    test_out_of_range();
`ifdef MUXN_SEQ_SKIP_EN
    test_skip();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muxn_seq.md
# muxn_seq

Parametrised N-channel, WIDTH-bit registered multiplexer, successor to the single-bit 2:1 mux cell. It adds a registered output, an out-of-range select error flag, and an automatic round-robin mode that steps through the channels with a programmable dwell time. It sits between multi-source datapaths and a single downstream consumer, for example scanning several status buses onto one monitor port.

## Interface
- N, 4, number of input channels (≥2)
- WIDTH, 8, bits per channel (≥1)
- DWELL, 2, cycles each channel stays selected in auto mode (≥1)
- SW = $clog2(N), derived (localparam), select width
---
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- d  in  N*WIDTH  packed channel data; channel k = d[k*WIDTH +: WIDTH]
- sel  in  SW  manual channel select
- mode  in  1  0 = manual, 1 = auto round-robin
- en  in  1  clock enable; low freezes all state and outputs
- z  out  WIDTH  registered selected data
- cur_sel  out  SW  channel index that produced the current z
- z_valid  out  1  high when z holds a legal channel sample
- sel_err  out  1  high when the last manual sample used sel ≥ N

## Operation
- Reset values: z=0, cur_sel=0, z_valid=0, sel_err=0, internal ptr=0, dwell cnt=0, state=MAN.
- The block has two states:
  - MAN: entered when mode=0.
  - AUTO: entered when mode=1.
  - The state is evaluated on every edge where en=1.
- MAN, en=1, sel<N: z←d[sel], cur_sel←sel, z_valid←1, sel_err←0.
- MAN, en=1, sel≥N (only reachable when N is not a power of 2): z←0, cur_sel←0, z_valid←0, sel_err←1.
- MAN→AUTO transition (mode goes 1 while in MAN): ptr←sel if sel<N, else 0; cnt←0. The sample on this edge uses the new ptr value.
- AUTO, en=1:
  - z←d[ptr], cur_sel←ptr, z_valid←1, sel_err←0.
  - If cnt==DWELL-1, then cnt←0 and ptr←(ptr==N-1)?0:ptr+1; else cnt←cnt+1.
- AUTO→MAN transition: takes effect on the same edge; that edge samples d[sel]. ptr and cnt retain their values but are reloaded on the next MAN→AUTO transition.
- en=0: no register changes, including ptr and cnt. Dwell counting is in enabled cycles only.
- rst has priority over en and mode. Asserting rst mid-dwell returns to state MAN with ptr=0 on the next edge.

## Timing
- Latency is 1 cycle: z, cur_sel, z_valid and sel_err after edge t reflect d/sel/mode sampled at edge t.
- There is no combinational path from any input to any output.
- Auto sequence with N=4, DWELL=2, starting ptr=0, en held high: cur_sel = 0,0,1,1,2,2,3,3,0,0,…
- Wrap-around: ptr advances from N-1 to 0 with no idle cycle.
- A mode change and a sel change in the same cycle: the new mode decides the path, and the new sel is used for the MAN→AUTO load.
- Throughput: one sample per enabled cycle, in both modes.

## Configuration
- Macro: MUXN_SEQ_SKIP_EN.
- Defined: adds input `ch_vld` (N bits, one per channel). In AUTO, when advancing, ptr moves to the next index (with wrap) whose ch_vld bit is 1.
  - If no bit is set: z_valid←0, z holds its value, ptr holds.
  - If the current channel's ch_vld is 0 at the sample edge: z_valid←0.
  - MAN mode is unaffected by ch_vld.
- Undefined: the ch_vld port is absent and AUTO visits every channel in strict order.

## Test plan
- Reset:
  - Stimulus: assert rst for 2 cycles with mode=1 and en=1.
  - Required response: z=0, cur_sel=0, z_valid=0, sel_err=0. First edge after release is in MAN.
- Manual select:
  - Stimulus: N=4, WIDTH=8, d={8'h44,8'h33,8'h22,8'h11}, mode=0; sel = 2, then 0, then 3 on consecutive edges.
  - Required response: z = 8'h33, 8'h11, 8'h44, each 1 cycle after its sel is applied.
- Auto round-robin and wrap:
  - Stimulus: same d, sel=2, mode rises to 1, DWELL=2, run 10 enabled cycles.
  - Required response: cur_sel = 2,2,3,3,0,0,1,1,2,2, with z matching each channel.
- Enable freeze:
  - Stimulus: in AUTO with cnt=1, drop en for 3 cycles while changing d.
  - Required response: z, cur_sel and ptr are unchanged during the freeze. The first enabled edge after it completes the dwell, and ptr advances on that edge.
- Out-of-range select:
  - Stimulus: N=3, mode=0, sel=3.
  - Required response: z=0, z_valid=0, sel_err=1. Then with sel=1: z=d[1], sel_err=0.
- Skip (MUXN_SEQ_SKIP_EN defined):
  - Stimulus: N=4, DWELL=1, ch_vld=4'b1010, start ptr=1.
  - Required response: cur_sel = 1,3,1,3. Then ch_vld=0 gives z_valid=0 with z held.
